pl_dac_stream: RTL

//  Transmit-side counterpart of the CMOS ADC capture path: accepts a burst of sample words on an
//  AXI-Stream slave port and drives them onto the 12-bit parallel CMOS DAC bus, one per i_CMOS_Clk.

---
 rtl/pl_adc_pkg.sv | 20 ++
 rtl/pl_dac_stream_if.sv | 12 +
 rtl/pl_dac_fifo.sv | 59 +++++
 rtl/pl_dac_stream.sv | 119 +++++++++++
 4 files changed

// File: rtl/pl_adc_pkg.sv
// Definitions shared by the CMOS ADC/DAC data paths: the burst sequencer states and the bus defaults.
package pl_adc_pkg;

  localparam int          PL_DATA_W    = 12;
  localparam logic [11:0] PL_IDLE_CODE = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DONE
  } pl_state_e;

  // The burst may start once the FIFO cannot take any more words, or already holds the whole burst.
  function automatic logic prime_ready(input logic full, input logic [31:0] level,
                                       input logic [31:0] count);
    return full || (level >= count);
  endfunction

endpackage

// File: rtl/pl_dac_stream_if.sv
// AXI-Stream sample port that feeds the DAC burst engine.
interface pl_dac_stream_if #(
  parameter int AXIS_W = 16
);
  logic [AXIS_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pl_dac_fifo.sv
// Synchronous FIFO that holds {tlast, sample}. Its registered read port is the DAC bus register itself,
// so it can also be loaded with the idle word.
module pl_dac_fifo #(
  parameter int            W     = 13,
  parameter int            DEPTH = 16,
  parameter logic [W-1:0]  INIT  = '0,
  localparam int           AW    = $clog2(DEPTH),
  localparam int           LW    = AW + 1
) (
  input  logic          i_CMOS_Clk,
  input  logic          i_Reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          load,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_CMOS_Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_CMOS_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= INIT;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end else if (load) begin
        rd_data <= INIT;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pl_dac_stream.sv
// Burst sequencer that moves samples from the AXI-Stream FIFO onto the 12-bit CMOS DAC bus.
//  state    | meaning
//  ST_IDLE  | bus at idle code, FIFO may pre-fill, waiting for work
//  ST_PRIME | burst latched, waiting for enough buffered samples
//  ST_RUN   | one pop per cycle while the FIFO has data
//  ST_DONE  | burst finished, done held until work drops
module pl_dac_stream
  import pl_adc_pkg::*;
#(
  parameter int                DATA_W     = PL_DATA_W,
  parameter int                AXIS_W     = 16,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] IDLE_CODE  = PL_IDLE_CODE
) (
  input  logic                 i_CMOS_Clk,
  input  logic                 i_Reset,
  pl_dac_stream_if.slave       s_axis,
  input  logic                 i_DAC_Work,
  input  logic [31:0]          i_Count,
  output logic [DATA_W-1:0]    o_CMOS_Data,
  output logic                 o_DAC_Done,
  output logic                 o_DAC_Last,
  output logic                 o_Underflow,
  output logic                 o_Tlast_Err
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  pl_state_e     state, state_nxt;
  logic [31:0]   r_count;
  logic [31:0]   r_idx;
  logic          r_pop_d;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [DATA_W:0] fifo_rd;
  logic          push, pop, load, start, final_pop;
  logic          unused_axis_hi;

  assign s_axis.tready  = !fifo_full && !i_Reset;
  assign push           = s_axis.tvalid && s_axis.tready;
  assign final_pop      = pop && (r_idx == r_count - 32'd1);
  assign o_CMOS_Data    = fifo_rd[DATA_W-1:0];
  assign unused_axis_hi = ^s_axis.tdata[AXIS_W-1:DATA_W];

  pl_dac_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .INIT  ({1'b0, IDLE_CODE})
  ) u_fifo (
    .i_CMOS_Clk (i_CMOS_Clk),
    .i_Reset    (i_Reset),
    .push       (push),
    .push_data  ({s_axis.tlast, s_axis.tdata[DATA_W-1:0]}),
    .pop        (pop),
    .load       (load),
    .rd_data    (fifo_rd),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start     = 1'b0;
    case (state)
      ST_IDLE: if (i_DAC_Work) begin
        start     = 1'b1;
        state_nxt = (i_Count == 32'd0) ? ST_DONE : ST_PRIME;
      end
      ST_PRIME: begin
        if (!i_DAC_Work) state_nxt = ST_IDLE;
        else if (prime_ready(fifo_full, 32'(fifo_level), r_count)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!i_DAC_Work) begin
          state_nxt = ST_IDLE;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (r_idx == r_count - 32'd1) state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (!i_DAC_Work) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Underflow keeps the last sample on the bus; every other non-popping cycle parks it at idle.
    load = (state_nxt != ST_RUN) && !pop;
  end

  always_ff @(posedge i_CMOS_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_pop_d     <= 1'b0;
      o_DAC_Done  <= 1'b0;
      o_DAC_Last  <= 1'b0;
      o_Underflow <= 1'b0;
      o_Tlast_Err <= 1'b0;
    end else begin
      state      <= state_nxt;
      r_pop_d    <= pop;
      o_DAC_Last <= final_pop;
      o_DAC_Done <= (state_nxt == ST_DONE) && !final_pop;
      if (start) begin
        r_count     <= i_Count;
        r_idx       <= '0;
        o_Underflow <= 1'b0;
        o_Tlast_Err <= 1'b0;
      end else begin
        if (pop) r_idx <= r_idx + 32'd1;
        if ((state == ST_RUN) && i_DAC_Work && fifo_empty) o_Underflow <= 1'b1;
        // The popped tlast lands in the read register alongside the matching o_DAC_Last.
        if (r_pop_d && (fifo_rd[DATA_W] != o_DAC_Last)) o_Tlast_Err <= 1'b1;
      end
    end
  end

endmodule
